// File: rtl/alarm_tone_gen_if.sv
// Signal bundle between the alarm sounder and its controller: time/alarm
// comparison inputs, user controls and the buzzer/status outputs.
interface alarm_tone_gen_if;
  logic        en;
  logic [13:0] now_time;
  logic [13:0] alm_time;
  logic        min_tick;
  logic        snooze;
  logic        stop;
  logic        beep;
  logic        ringing;
  logic        snoozing;

  // Controller side: drives time and user inputs, observes the sounder.
  modport master (
    output en, now_time, alm_time, min_tick, snooze, stop,
    input  beep, ringing, snoozing
  );

  // Sounder side.
  modport slave (
    input  en, now_time, alm_time, min_tick, snooze, stop,
    output beep, ringing, snoozing
  );
endinterface

// File: rtl/alarm_tone_gen.sv
// Alarm sounder: rings on the first cycle the BCD time equals the alarm time,
// plays a two-tone square wave while ringing, and handles snooze, stop and an
// automatic timeout counted in minute ticks.
module alarm_tone_gen #(
  parameter int unsigned HALF_A      = 31249,
  parameter int unsigned HALF_B      = 249999,
  parameter int unsigned SEG_CYC     = 16777216,
  parameter int unsigned SNOOZE_MIN  = 5,
  parameter int unsigned TIMEOUT_MIN = 5
) (
  input  logic              mclk,
  input  logic              rst_n,
  alarm_tone_gen_if.slave   bus
);

  localparam int unsigned HP_MAX  = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int unsigned HP_W    = (HP_MAX < 1) ? 1 : $clog2(HP_MAX + 1);
  localparam int unsigned SEG_W   = (SEG_CYC < 2) ? 1 : $clog2(SEG_CYC);
  localparam int unsigned MIN_MAX = (SNOOZE_MIN > TIMEOUT_MIN) ? SNOOZE_MIN : TIMEOUT_MIN;
  localparam int unsigned MIN_W   = (MIN_MAX < 1) ? 1 : $clog2(MIN_MAX + 1);

  localparam logic [HP_W-1:0]  HP_A     = HP_W'(HALF_A);
  localparam logic [HP_W-1:0]  HP_B     = HP_W'(HALF_B);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_CYC - 1);
  localparam logic [MIN_W-1:0] SN_LIM   = MIN_W'(SNOOZE_MIN);
  localparam logic [MIN_W-1:0] TO_LIM   = MIN_W'(TIMEOUT_MIN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_match_d;
  logic               r_beep;
  logic               r_ringing;
  logic               r_snoozing;
  logic               r_seg;
  logic [SEG_W-1:0]   r_seg_cnt;
  logic [HP_W-1:0]    r_hp_cnt;
  logic [MIN_W-1:0]   r_min_cnt;

  state_t             w_state_next;
  logic               w_beep_next;
  logic               w_seg_next;
  logic [SEG_W-1:0]   w_seg_cnt_next;
  logic [HP_W-1:0]    w_hp_cnt_next;
  logic [MIN_W-1:0]   w_min_cnt_next;
  logic               w_tone_load;
  logic               w_match;
  logic               w_start;
  logic               w_quit;
  logic [MIN_W-1:0]   w_min_inc;

  // Rising edge of the time match; match_d powering up at 1 keeps a match
  // that is already present at reset release from ringing.
  assign w_match   = (bus.now_time == bus.alm_time);
  assign w_start   = bus.en & w_match & ~r_match_d;
  assign w_quit    = bus.stop | ~bus.en;
  assign w_min_inc = r_min_cnt + 1'b1;

  // Next-state, minute bookkeeping and tone generation.
  always_comb begin
    w_state_next   = r_state;
    w_beep_next    = r_beep;
    w_seg_next     = r_seg;
    w_seg_cnt_next = r_seg_cnt;
    w_hp_cnt_next  = r_hp_cnt;
    w_min_cnt_next = r_min_cnt;
    w_tone_load    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_RING;
          w_tone_load  = 1'b1;
        end
      end
      ST_RING: begin
        // stop/snooze take priority; a coincident minute tick is dropped
        if (w_quit) begin
          w_state_next = ST_IDLE;
        end else if (bus.snooze) begin
          w_state_next   = ST_SNOOZE;
          w_min_cnt_next = '0;
        end else if (bus.min_tick) begin
          if (w_min_inc == TO_LIM) begin
            w_state_next = ST_IDLE;
          end else begin
            w_min_cnt_next = w_min_inc;
          end
        end
      end
      ST_SNOOZE: begin
        if (w_quit) begin
          w_state_next = ST_IDLE;
        end else if (bus.min_tick) begin
          if (w_min_inc == SN_LIM) begin
            w_state_next = ST_RING;
            w_tone_load  = 1'b1;
          end else begin
            w_min_cnt_next = w_min_inc;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_tone_load) begin
      // Every ring episode starts fresh on tone A with beep low.
      w_seg_next     = 1'b0;
      w_seg_cnt_next = '0;
      w_hp_cnt_next  = HP_A;
      w_beep_next    = 1'b0;
      w_min_cnt_next = '0;
    end else if (w_state_next == ST_RING) begin
      // Staying in RING: run the square wave. The reload uses the segment
      // currently in force, so a segment switch only affects the next
      // half-period.
      if (r_hp_cnt == '0) begin
        w_beep_next   = ~r_beep;
        w_hp_cnt_next = r_seg ? HP_B : HP_A;
      end else begin
        w_hp_cnt_next = r_hp_cnt - 1'b1;
      end
      if (r_seg_cnt == SEG_LAST) begin
        w_seg_cnt_next = '0;
        w_seg_next     = ~r_seg;
      end else begin
        w_seg_cnt_next = r_seg_cnt + 1'b1;
      end
    end else begin
      // Not ringing: buzzer silent, tone counters hold.
      w_beep_next = 1'b0;
    end
  end

  // State and datapath registers; status flags decoded from the next state
  // so they line up with the state register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_match_d  <= 1'b1;
      r_beep     <= 1'b0;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
      r_seg      <= 1'b0;
      r_seg_cnt  <= '0;
      r_hp_cnt   <= '0;
      r_min_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_match_d  <= w_match;
      r_beep     <= w_beep_next;
      r_ringing  <= (w_state_next == ST_RING);
      r_snoozing <= (w_state_next == ST_SNOOZE);
      r_seg      <= w_seg_next;
      r_seg_cnt  <= w_seg_cnt_next;
      r_hp_cnt   <= w_hp_cnt_next;
      r_min_cnt  <= w_min_cnt_next;
    end
  end

  assign bus.beep     = r_beep;
  assign bus.ringing  = r_ringing;
  assign bus.snoozing = r_snoozing;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Directed testbench for alarm_tone_gen with short tone/timeout parameters.
module tb_alarm_tone_gen;

  logic mclk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alarm_tone_gen_if bus_if ();

  alarm_tone_gen #(
    .HALF_A      (3),
    .HALF_B      (1),
    .SEG_CYC     (16),
    .SNOOZE_MIN  (2),
    .TIMEOUT_MIN (3)
  ) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // BCD HH:MM packed as {h_tens[2:0], h_units[3:0], m_tens[2:0], m_units[3:0]}
  function automatic logic [13:0] hm(input int h, input int m);
    logic [2:0] ht;
    logic [3:0] hu;
    logic [2:0] mt;
    logic [3:0] mu;
    ht = 3'(h / 10);
    hu = 4'(h % 10);
    mt = 3'(m / 10);
    mu = 4'(m % 10);
    return {ht, hu, mt, mu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_tick();
    bus_if.min_tick = 1'b1;
    tick();
    bus_if.min_tick = 1'b0;
  endtask

  // Break then restore the match so the next edge starts a ring at 07:00.
  task automatic retrigger();
    bus_if.now_time = hm(7, 1);
    tick();
    bus_if.now_time = hm(7, 0);
    tick();
  endtask

  // Edges after RING entry at which beep toggles (tone A x4, then tone B).
  int toggle_edges [13] = '{4, 8, 12, 16, 20, 22, 24, 26, 28, 30, 32, 34, 38};

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    rst_n           = 1'b0;
    bus_if.en       = 1'b1;
    bus_if.alm_time = hm(12, 30);
    bus_if.now_time = hm(12, 29);
    bus_if.min_tick = 1'b0;
    bus_if.snooze   = 1'b0;
    bus_if.stop     = 1'b0;
    ticks(2);
    chk("rst_beep", 32'(bus_if.beep), 0);
    chk("rst_ringing", 32'(bus_if.ringing), 0);
    chk("rst_snoozing", 32'(bus_if.snoozing), 0);
    rst_n = 1'b1;
    ticks(2);
    chk("t1_pre_ringing", 32'(bus_if.ringing), 0);

    // 1: match appears after edge k, ringing after edge k+1, two-tone pattern
    bus_if.now_time = hm(12, 30);
    tick();
    chk("t1_ringing", 32'(bus_if.ringing), 1);
    chk("t1_beep0", 32'(bus_if.beep), 0);
    for (int n = 1; n <= 40; n++) begin
      tick();
      cnt = 0;
      for (int j = 0; j < 13; j++) if (toggle_edges[j] <= n) cnt++;
      chk($sformatf("t1_beep_e%0d", n), 32'(bus_if.beep), 32'(cnt % 2));
    end
    chk("t1_still_ringing", 32'(bus_if.ringing), 1);
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    chk("t1_stop_ringing", 32'(bus_if.ringing), 0);
    chk("t1_stop_beep", 32'(bus_if.beep), 0);
    ticks(3);
    chk("t1_no_rering", 32'(bus_if.ringing), 0);

    // 2: match present at reset release does not ring
    rst_n = 1'b0;
    bus_if.alm_time = hm(7, 0);
    bus_if.now_time = hm(7, 0);
    tick();
    rst_n = 1'b1;
    ticks(3);
    chk("t2_no_ring", 32'(bus_if.ringing), 0);
    retrigger();
    chk("t2_ringing", 32'(bus_if.ringing), 1);

    // 3: snooze, two minutes, re-ring at tone A, stop
    ticks(5);
    chk("t3_beep_high", 32'(bus_if.beep), 1);
    bus_if.snooze = 1'b1;
    tick();
    bus_if.snooze = 1'b0;
    chk("t3_snoozing", 32'(bus_if.snoozing), 1);
    chk("t3_snz_ringing", 32'(bus_if.ringing), 0);
    chk("t3_snz_beep", 32'(bus_if.beep), 0);
    ticks(2);
    pulse_tick();
    chk("t3_after_tick1", 32'(bus_if.snoozing), 1);
    tick();
    pulse_tick();
    chk("t3_rering", 32'(bus_if.ringing), 1);
    chk("t3_rering_snz", 32'(bus_if.snoozing), 0);
    chk("t3_rering_beep", 32'(bus_if.beep), 0);
    ticks(3);
    chk("t3_toneA_e3", 32'(bus_if.beep), 0);
    tick();
    chk("t3_toneA_e4", 32'(bus_if.beep), 1);
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    chk("t3_stop_ringing", 32'(bus_if.ringing), 0);
    chk("t3_stop_snoozing", 32'(bus_if.snoozing), 0);
    chk("t3_stop_beep", 32'(bus_if.beep), 0);

    // 4: auto-timeout after three minute ticks, no re-ring while matched
    retrigger();
    chk("t4_ringing", 32'(bus_if.ringing), 1);
    pulse_tick();
    chk("t4_tick1", 32'(bus_if.ringing), 1);
    tick();
    pulse_tick();
    chk("t4_tick2", 32'(bus_if.ringing), 1);
    tick();
    pulse_tick();
    chk("t4_timeout", 32'(bus_if.ringing), 0);
    chk("t4_timeout_beep", 32'(bus_if.beep), 0);
    ticks(5);
    chk("t4_no_rering", 32'(bus_if.ringing), 0);

    // 5: snooze wins over a coincident tick; en low cancels snooze
    retrigger();
    chk("t5_ringing", 32'(bus_if.ringing), 1);
    bus_if.snooze   = 1'b1;
    bus_if.min_tick = 1'b1;
    tick();
    bus_if.snooze   = 1'b0;
    bus_if.min_tick = 1'b0;
    chk("t5_snoozing", 32'(bus_if.snoozing), 1);
    pulse_tick();
    chk("t5_one_tick_only", 32'(bus_if.snoozing), 1);
    chk("t5_not_ringing", 32'(bus_if.ringing), 0);
    bus_if.en = 1'b0;
    tick();
    chk("t5_en_off_snz", 32'(bus_if.snoozing), 0);
    chk("t5_en_off_ring", 32'(bus_if.ringing), 0);
    bus_if.en = 1'b1;
    tick();

    // 6: asynchronous reset mid-ring with beep high
    retrigger();
    chk("t6_ringing", 32'(bus_if.ringing), 1);
    ticks(4);
    chk("t6_beep_high", 32'(bus_if.beep), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_beep", 32'(bus_if.beep), 0);
    chk("t6_async_ringing", 32'(bus_if.ringing), 0);
    tick();
    rst_n = 1'b1;
    ticks(3);
    chk("t6_no_ring", 32'(bus_if.ringing), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
